// File: rtl/uart_pkg.sv
// Shared UART-side types: arbiter state encoding, TxUnit parity/baud encodings, data width.
// No logic of its own; imported by tx_arbiter and its helpers.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        BUSY     = 2'd2,
        COMPLETE = 2'd3
    } arbState_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2,
        PAR_MARK = 2'd3
    } parityType_t;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'd0,
        BAUD_4800  = 2'd1,
        BAUD_9600  = 2'd2,
        BAUD_19200 = 2'd3
    } baudRate_t;

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester-side and TxUnit-side bundle around tx_arbiter; master is the arbiter's view.
// Requests are level-held until ReqAck/ReqErr; TxUnit progress is reported by ActiveFlag/DoneFlag.
interface tx_arbiter_if import uart_pkg::*; #(
    parameter int NUM_REQ = 4
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic [NUM_REQ*2-1:0]      ReqParity;
    logic [NUM_REQ*2-1:0]      ReqBaud;
    logic [NUM_REQ-1:0]        ReqStopBits;
    logic [NUM_REQ-1:0]        ReqDataLength;
    logic [NUM_REQ-1:0]        ReqAck;
    logic [NUM_REQ-1:0]        ReqErr;

    logic                      Send;
    logic [DATA_W-1:0]         DataIn;
    logic [1:0]                ParityType;
    logic [1:0]                BaudRate;
    logic                      StopBits;
    logic                      DataLength;
    logic                      ActiveFlag;
    logic                      DoneFlag;

    logic                      Busy;
    logic [IDX_W-1:0]          GrantIdx;

    modport master (
        input  ReqValid, ReqData, ReqParity, ReqBaud, ReqStopBits, ReqDataLength,
        input  ActiveFlag, DoneFlag,
        output ReqAck, ReqErr,
        output Send, DataIn, ParityType, BaudRate, StopBits, DataLength,
        output Busy, GrantIdx
    );

    modport slave (
        output ReqValid, ReqData, ReqParity, ReqBaud, ReqStopBits, ReqDataLength,
        output ActiveFlag, DoneFlag,
        input  ReqAck, ReqErr,
        input  Send, DataIn, ParityType, BaudRate, StopBits, DataLength,
        input  Busy, GrantIdx
    );

endinterface

// File: rtl/tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after lastGrant, wrapping to 0.
// Zero latency; no flow control of its own, the caller decides when to consume the winner.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [IDX_W-1:0]   lastGrant,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        any    = |reqVec;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(lastGrant) + k) % NUM_REQ);
            if (reqVec[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin owner of one TxUnit: latches a requester's byte+config, launches one frame, acks or aborts.
// Request to Send in one cycle; requesters hold ReqValid until ReqAck/ReqErr, a stuck start is aborted by the watchdog.
module tx_arbiter import uart_pkg::*; #(
    parameter int NUM_REQ       = 4,
    parameter int IDX_W         = $clog2(NUM_REQ),
    parameter int START_TIMEOUT = 1023
) (
    input  logic          Clock,
    input  logic          Reset,
    tx_arbiter_if.master  bus
);

    localparam int WD_W = $clog2(START_TIMEOUT + 1);

    arbState_t          state;
    logic [IDX_W-1:0]   lastGrant;
    logic [IDX_W-1:0]   pickIdx;
    logic               pickAny;
    logic [WD_W-1:0]    wdCnt;
    logic [NUM_REQ-1:0] grantOneHot;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) uPicker (
        .reqVec    (bus.ReqValid),
        .lastGrant (lastGrant),
        .winner    (pickIdx),
        .any       (pickAny)
    );

    assign grantOneHot = NUM_REQ'(1) << bus.GrantIdx;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            lastGrant      <= IDX_W'(NUM_REQ - 1);
            wdCnt          <= '0;
            bus.Send       <= 1'b0;
            bus.ReqAck     <= '0;
            bus.ReqErr     <= '0;
            bus.Busy       <= 1'b0;
            bus.GrantIdx   <= '0;
            bus.DataIn     <= '0;
            bus.ParityType <= '0;
            bus.BaudRate   <= '0;
            bus.StopBits   <= 1'b0;
            bus.DataLength <= 1'b1;
        end else begin
            bus.ReqAck <= '0;
            bus.ReqErr <= '0;
            case (state)
                IDLE: begin
                    if (pickAny) begin
                        state          <= LAUNCH;
                        bus.Send       <= 1'b1;
                        bus.Busy       <= 1'b1;
                        bus.GrantIdx   <= pickIdx;
                        wdCnt          <= '0;
                        bus.DataIn     <= bus.ReqData[DATA_W*int'(pickIdx) +: DATA_W];
                        bus.ParityType <= bus.ReqParity[2*int'(pickIdx) +: 2];
                        bus.BaudRate   <= bus.ReqBaud[2*int'(pickIdx) +: 2];
                        bus.StopBits   <= bus.ReqStopBits[pickIdx];
                        bus.DataLength <= bus.ReqDataLength[pickIdx];
                    end
                end
                LAUNCH: begin
                    // wdCnt holds the LAUNCH cycles already spent; this one is number wdCnt+1.
                    if (bus.ActiveFlag) begin
                        state    <= BUSY;
                        bus.Send <= 1'b0;
                    end else if (int'(wdCnt) + 1 == START_TIMEOUT) begin
                        state      <= IDLE;
                        bus.Send   <= 1'b0;
                        bus.Busy   <= 1'b0;
                        bus.ReqErr <= grantOneHot;
                        lastGrant  <= bus.GrantIdx;
                    end else begin
                        wdCnt <= wdCnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.DoneFlag) begin
                        state      <= COMPLETE;
                        bus.ReqAck <= grantOneHot;
                        lastGrant  <= bus.GrantIdx;
                    end
                end
                COMPLETE: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                    bus.Send <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: cycle vector table plus watchdog, config-isolation and reset sequences.
module tb_tx_arbiter;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    tx_arbiter_if #(.NUM_REQ(4)) bus ();

    tx_arbiter #(
        .NUM_REQ       (4),
        .IDX_W         (2),
        .START_TIMEOUT (15)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       send;
        logic [3:0] ack;
        logic [3:0] err;
        logic       busy;
        logic [1:0] grant;
        logic [7:0] dataIn;
        logic [1:0] parity;
        logic [1:0] baud;
        logic       stop;
        logic       len;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [3:0] rv;
        logic       act;
        logic       done;
        outs_t      exp;
    } vec_t;

    vec_t       vecs[$];
    int         checks = 0;
    int         passes = 0;
    logic [7:0] reqBytes[4];
    outs_t      rstOut;

    function automatic outs_t sample();
        outs_t s;
        s.send   = bus.Send;
        s.ack    = bus.ReqAck;
        s.err    = bus.ReqErr;
        s.busy   = bus.Busy;
        s.grant  = bus.GrantIdx;
        s.dataIn = bus.DataIn;
        s.parity = bus.ParityType;
        s.baud   = bus.BaudRate;
        s.stop   = bus.StopBits;
        s.len    = bus.DataLength;
        return s;
    endfunction

    function automatic vec_t mk(logic rst, logic [3:0] rv, logic act, logic done,
                                logic send, logic [3:0] ack, logic busy,
                                logic [1:0] grant, logic [7:0] dat);
        vec_t v;
        v.rst  = rst;
        v.rv   = rv;
        v.act  = act;
        v.done = done;
        v.exp  = '{send: send, ack: ack, err: 4'b0000, busy: busy, grant: grant,
                   dataIn: dat, parity: 2'd0, baud: 2'd0, stop: 1'b0, len: 1'b1};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic setIn(input logic [3:0] rv, input logic act, input logic done);
        bus.ReqValid   = rv;
        bus.ActiveFlag = act;
        bus.DoneFlag   = done;
    endtask

    task automatic cfgDefault();
        bus.ReqData       = {8'hD3, 8'hC2, 8'hB1, 8'hAA};
        bus.ReqParity     = 8'h00;
        bus.ReqBaud       = 8'h00;
        bus.ReqStopBits   = 4'b0000;
        bus.ReqDataLength = 4'b1111;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        setIn(4'b0000, 1'b0, 1'b0);
        step();
        Reset = 1'b0;
    endtask

    initial begin
        logic [1:0] order[5];
        logic [3:0] oh;
        reqBytes = '{8'hAA, 8'hB1, 8'hC2, 8'hD3};
        order    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rstOut   = '{send: 1'b0, ack: 4'b0, err: 4'b0, busy: 1'b0, grant: 2'd0,
                     dataIn: 8'h00, parity: 2'd0, baud: 2'd0, stop: 1'b0, len: 1'b1};
        cfgDefault();
        setIn(4'b0000, 1'b0, 1'b0);

        // Single requester: grant, launch, busy, ack, idle.
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 8'h00));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 8'h00));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 1, 4'b0000, 1, 2'd0, 8'hAA));
        vecs.push_back(mk(0, 4'b0001, 0, 0, 1, 4'b0000, 1, 2'd0, 8'hAA));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 0, 4'b0000, 1, 2'd0, 8'hAA));
        vecs.push_back(mk(0, 4'b0001, 1, 0, 0, 4'b0000, 1, 2'd0, 8'hAA));
        vecs.push_back(mk(0, 4'b0001, 0, 1, 0, 4'b0001, 1, 2'd0, 8'hAA));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 8'hAA));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 8'hAA));
        // Fairness with all four requesting: order 0,1,2,3,0.
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 8'h00));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd0, 8'h00));
        for (int f = 0; f < 5; f++) begin
            oh = 4'b0001 << order[f];
            vecs.push_back(mk(0, 4'b1111, 0, 0, 1, 4'b0000, 1, order[f], reqBytes[order[f]]));
            vecs.push_back(mk(0, 4'b1111, 1, 0, 0, 4'b0000, 1, order[f], reqBytes[order[f]]));
            vecs.push_back(mk(0, 4'b1111, 0, 1, 0, oh,      1, order[f], reqBytes[order[f]]));
            vecs.push_back(mk(0, 4'b1111, 0, 0, 0, 4'b0000, 0, order[f], reqBytes[order[f]]));
        end
        // Withdrawal: requester 1 drops mid-frame, ack still comes.
        vecs.push_back(mk(0, 4'b0010, 0, 0, 1, 4'b0000, 1, 2'd1, 8'hB1));
        vecs.push_back(mk(0, 4'b0010, 1, 0, 0, 4'b0000, 1, 2'd1, 8'hB1));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 1, 2'd1, 8'hB1));
        vecs.push_back(mk(0, 4'b0000, 0, 1, 0, 4'b0010, 1, 2'd1, 8'hB1));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'd1, 8'hB1));

        foreach (vecs[i]) begin
            Reset = vecs[i].rst;
            setIn(vecs[i].rv, vecs[i].act, vecs[i].done);
            step();
            chk($sformatf("vec%0d", i), sample(), vecs[i].exp);
        end

        // Config isolation: requester 2 config frozen while its frame runs.
        doReset();
        bus.ReqBaud       = 8'b00_10_00_00;
        bus.ReqParity     = 8'b00_01_00_00;
        bus.ReqStopBits   = 4'b0100;
        bus.ReqDataLength = 4'b1011;
        setIn(4'b0100, 1'b0, 1'b0);
        step();
        chk("cfg_grant", {bus.Send, bus.GrantIdx, bus.DataIn, bus.ParityType, bus.BaudRate, bus.StopBits, bus.DataLength},
            {1'b1, 2'd2, 8'hC2, 2'd1, 2'd2, 1'b1, 1'b0});
        setIn(4'b0100, 1'b1, 1'b0);
        step();
        chk("cfg_busy", {bus.Send, bus.Busy}, {1'b0, 1'b1});
        bus.ReqBaud       = 8'b00_11_00_00;
        bus.ReqStopBits   = 4'b0000;
        bus.ReqDataLength = 4'b1111;
        bus.ReqData[23:16] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("cfg_hold%0d", k), {bus.BaudRate, bus.StopBits, bus.DataLength, bus.DataIn},
                {2'd2, 1'b1, 1'b0, 8'hC2});
        end
        setIn(4'b0100, 1'b0, 1'b1);
        step();
        chk("cfg_ack", {bus.ReqAck, bus.BaudRate, bus.DataLength}, {4'b0100, 2'd2, 1'b0});
        setIn(4'b0000, 1'b0, 1'b0);
        step();
        chk("cfg_idle", bus.Busy, 1'b0);
        cfgDefault();

        // Watchdog: ActiveFlag never rises, abort after 15 LAUNCH cycles.
        doReset();
        setIn(4'b0011, 1'b0, 1'b0);
        step();
        chk("wd_grant", {bus.Send, bus.GrantIdx}, {1'b1, 2'd0});
        for (int k = 1; k < 15; k++) begin
            step();
            chk($sformatf("wd_launch%0d", k), {bus.Send, bus.ReqErr}, {1'b1, 4'b0000});
        end
        step();
        chk("wd_abort", {bus.Send, bus.ReqErr, bus.ReqAck, bus.Busy}, {1'b0, 4'b0001, 4'b0000, 1'b0});
        setIn(4'b0010, 1'b0, 1'b0);
        step();
        chk("wd_next", {bus.Send, bus.GrantIdx, bus.ReqErr}, {1'b1, 2'd1, 4'b0000});
        for (int k = 1; k < 15; k++) begin
            step();
            chk($sformatf("wd2_launch%0d", k), {bus.Send, bus.ReqErr}, {1'b1, 4'b0000});
        end
        setIn(4'b0010, 1'b1, 1'b0);
        step();
        chk("wd_edge_win", {bus.Send, bus.ReqErr, bus.Busy}, {1'b0, 4'b0000, 1'b1});
        step();
        chk("wd_edge_busy", {bus.ReqErr, bus.Busy}, {4'b0000, 1'b1});
        setIn(4'b0010, 1'b0, 1'b1);
        step();
        chk("wd_edge_ack", {bus.ReqAck, bus.ReqErr}, {4'b0010, 4'b0000});
        setIn(4'b0000, 1'b0, 1'b0);
        step();

        // Reset in the middle of a frame.
        doReset();
        setIn(4'b0001, 1'b0, 1'b0);
        step();
        setIn(4'b0001, 1'b1, 1'b0);
        step();
        chk("rst_pre", {bus.Busy, bus.Send}, {1'b1, 1'b0});
        Reset = 1'b1;
        setIn(4'b0001, 1'b1, 1'b1);
        step();
        chk("rst_mid", sample(), rstOut);
        step();
        chk("rst_hold", sample(), rstOut);
        Reset = 1'b0;
        setIn(4'b0100, 1'b0, 1'b0);
        step();
        chk("rst_regrant", {bus.Send, bus.GrantIdx, bus.DataIn, bus.ReqAck}, {1'b1, 2'd2, 8'hC2, 4'b0000});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin scheduler that shares one `TxUnit` serial transmitter among `NUM_REQ` requesters, each carrying its own frame configuration (parity, baud, stop bits, data length). It sits directly in front of `TxUnit` and owns its `Send`, `DataIn` and configuration inputs. It sequences one complete frame per grant and acknowledges the requester on completion. A start watchdog aborts a grant if the transmitter never goes active.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IDX_W`, `$clog2(NUM_REQ)`: grant index width.
- `START_TIMEOUT`, 1023: maximum cycles in LAUNCH before abort.

- `Clock`  in  1  system clock (50 MHz in system).
- `Reset`  in  1  synchronous, active-high reset.
- `ReqValid`  in  NUM_REQ  per-requester frame pending; level, held until ack or error.
- `ReqData`  in  NUM_REQ*8  per-requester byte; slice i = [8i+7:8i].
- `ReqParity`  in  NUM_REQ*2  per-requester ParityType.
- `ReqBaud`  in  NUM_REQ*2  per-requester BaudRate.
- `ReqStopBits`  in  NUM_REQ  per-requester StopBits (0 = 1 stop, 1 = 2 stop).
- `ReqDataLength`  in  NUM_REQ  per-requester DataLength (1 = 8 bits, 0 = 7 bits).
- `ReqAck`  out  NUM_REQ  one-hot, one-cycle pulse: frame of that requester finished.
- `ReqErr`  out  NUM_REQ  one-hot, one-cycle pulse: grant aborted by watchdog.
- `Send`  out  1  to TxUnit.
- `DataIn`  out  8  to TxUnit.
- `ParityType`  out  2  to TxUnit.
- `BaudRate`  out  2  to TxUnit.
- `StopBits`  out  1  to TxUnit.
- `DataLength`  out  1  to TxUnit.
- `ActiveFlag`  in  1  from TxUnit: frame in progress.
- `DoneFlag`  in  1  from TxUnit: frame complete.
- `Busy`  out  1  high in any state other than IDLE.
- `GrantIdx`  out  IDX_W  index of the current or last owner.

## Operation
- States: IDLE, LAUNCH, BUSY, COMPLETE.
- **IDLE:**
  - If any `ReqValid`, select the winner by round-robin: search starts at `LastGrant+1` and wraps at `NUM_REQ-1` to 0.
  - Latch the winner's data and config into holding registers, set `GrantIdx`, clear the watchdog counter, and go to LAUNCH.
  - With no `ReqValid`, stay in IDLE.
- **LAUNCH:**
  - `Send`=1 and the counter increments each cycle.
  - `ActiveFlag`=1 → BUSY.
  - Counter = `START_TIMEOUT` → pulse `ReqErr[GrantIdx]`, update `LastGrant`, go to IDLE.
- **BUSY:** `Send`=0. On `DoneFlag`=1 go to COMPLETE. BUSY has no timeout; frame duration depends on baud.
- **COMPLETE:** pulse `ReqAck[GrantIdx]`, set `LastGrant`=`GrantIdx`, go to IDLE.
- **Config outputs** (`DataIn`, `ParityType`, `BaudRate`, `StopBits`, `DataLength`):
  - Driven from the holding registers only.
  - Stable from the LAUNCH entry cycle through COMPLETE.
  - Requester input changes after the grant are ignored.
- **Requester deassertion:** a requester dropping `ReqValid` mid-grant does not abort the grant. The frame completes and the ack is still issued.
- **Requester obligation:** `ReqValid[i]` must drop in the cycle after `ReqAck[i]`/`ReqErr[i]`, or a new frame is requested. The arbiter re-grants it only when round-robin order reaches it again.

## Timing
- **Reset values:**
  - State IDLE.
  - `Send`, `ReqAck`, `ReqErr`, `Busy` = 0.
  - `DataIn`=0, `ParityType`=0, `BaudRate`=0, `StopBits`=0, `DataLength`=1.
  - `GrantIdx`=0, `LastGrant`=`NUM_REQ-1`, so requester 0 wins first.
- **Request to Send latency:** `ReqValid` seen at edge N → `Send`=1 from edge N+1.
- **Send deassertion:** `Send` falls the cycle after `ActiveFlag` is sampled high.
- **Ack timing:** `DoneFlag` sampled at edge M → `ReqAck` high for cycle M+1 only. The next arbitration is evaluated at M+2, giving one idle cycle between frames.
- **DoneFlag in LAUNCH:** ignored; only `ActiveFlag` advances LAUNCH.
- **Watchdog boundary:**
  - Abort fires on the cycle the counter equals `START_TIMEOUT`.
  - `ActiveFlag` in that same cycle wins: go to BUSY, no error.
- **Reset mid-frame:** returns immediately to reset values, with no ack or error pulse. The TxUnit is reset separately by the system.
- **Outputs:** all outputs are registered.

## Structure
- **Shared package `uart_pkg`:**
  - State enum.
  - ParityType and BaudRate encodings (`PAR_NONE`=0..3, `BAUD_*`=0..3).
  - `DATA_W`=8.
- **Sub-module `rr_picker`:** combinational; request vector plus last grant in, winner index and `any` out. Reusable for a future Rx-side scheduler.
- **Top FSM and holding registers:** in `tx_arbiter`.

## Test plan
1. **Single requester:** reset, `ReqValid`=4'b0001, `ReqData[7:0]`=8'hAA, config {parity 0, baud 0, stop 0, length 1}, TxUnit model.
   - `Send`=1 one cycle later, `DataIn`=8'hAA.
   - One `ReqAck`=4'b0001 after `DoneFlag`; `Busy` returns to 0.
2. **Round-robin fairness:** `ReqValid`=4'b1111 held continuously.
   - Grant order 0,1,2,3,0.
   - Each `ReqAck` is one-hot and a single cycle.
3. **Config isolation:** requester 2 granted with baud 2, stop 1, length 0. Change `ReqBaud[5:4]` to 3 during BUSY.
   - `BaudRate` stays 2 until COMPLETE.
4. **Watchdog:** `START_TIMEOUT`=15, `ActiveFlag` held 0.
   - `ReqErr[GrantIdx]` pulses after 15 LAUNCH cycles, no `ReqAck`, next requester granted.
   - Repeat with `ActiveFlag`=1 on the 15th cycle: BUSY is entered, no error.
5. **Reset mid-frame:** `Reset`=1 during BUSY.
   - All outputs take reset values next cycle and no ack is emitted.
   - After release with `ReqValid`=4'b0100, requester 2 is granted.
6. **Withdrawal:** `ReqValid[1]` dropped during BUSY.
   - Frame completes and `ReqAck[1]` still pulses.
